alu_share_arbiter: RTL

//  Shares the single-cycle ALU between two requesters (req0: execute stage, req1: address/aux unit).

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// One transaction in flight: operands are registered on accept, the result is captured a cycle later.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int NUM_OPS = 10
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OP_W-1:0]          req0_op,
  input  logic signed [DATA_W-1:0] req0_a,
  input  logic signed [DATA_W-1:0] req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OP_W-1:0]          req1_op,
  input  logic signed [DATA_W-1:0] req1_a,
  input  logic signed [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]          alu_op,
  output logic signed [DATA_W-1:0] alu_a,
  output logic signed [DATA_W-1:0] alu_b,
  input  logic signed [DATA_W-1:0] alu_result,
  input  logic                     alu_negative,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic signed [DATA_W-1:0] rsp_result,
  output logic                     rsp_negative,
  output logic                     rsp_zero,
  output logic                     rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OP_W:0] NUM_OPS_EXT = (OP_W+1)'(NUM_OPS);

  state_t                     state, state_nxt;
  logic                       last_grant;
  logic                       grant;
  logic                       accept;
  logic [OP_W-1:0]            sel_op;
  logic signed [DATA_W-1:0]   sel_a, sel_b;
  logic                       id_p0;
  logic                       err_p0;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return {1'b0, op} >= NUM_OPS_EXT;
  endfunction

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    sel_op = grant ? req1_op : req0_op;
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept &&  grant;
  end

  // Issue stage: operands latched on accept, held while idle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_grant   <= 1'b1;
      id_p0        <= 1'b0;
      err_p0       <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        alu_op     <= sel_op;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        id_p0      <= grant;
        last_grant <= grant;
        err_p0     <= op_illegal(sel_op);
      end
      // Response stage: an illegal opcode masks whatever the ALU drove.
      if (state == EXEC) begin
        rsp_result   <= err_p0 ? '0 : alu_result;
        rsp_negative <= err_p0 ? 1'b0 : alu_negative;
        rsp_zero     <= err_p0 ? 1'b0 : alu_zero;
        rsp_id       <= id_p0;
        rsp_err      <= err_p0;
        rsp_valid    <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
